// File: rtl/sdram_axi_arb_pkg.sv
// Shared definitions for the 2:1 SDRAM AXI4 arbiter.
//  - state_e     : arbiter FSM state encoding (3 bits)
//  - PortS0/S1   : requester port indices
//  - port_onehot : converts an owner index to the one-hot grant vector
package sdram_axi_arb_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StAr   = 3'd1,
        StR    = 3'd2,
        StWr   = 3'd3,
        StB    = 3'd4
    } state_e;

    localparam logic PortS0 = 1'b0;
    localparam logic PortS1 = 1'b1;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdram_axi_arb2_if.sv
// AXI4 bundle (AW, W, B, AR, R) used between requesters, arbiter and controller.
//  master modport : drives address/data valids and response readies
//  slave modport  : drives address/data readies and response valids
interface sdram_axi_arb2_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) ();

    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic [ID_W-1:0]     awid;
    logic [7:0]          awlen;
    logic [1:0]          awburst;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;

    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic [ID_W-1:0]     bid;

    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic [ID_W-1:0]     arid;
    logic [7:0]          arlen;
    logic [1:0]          arburst;

    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic [ID_W-1:0]     rid;
    logic                rlast;

    modport master (
        output awvalid, awaddr, awid, awlen, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arburst,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready
    );

endinterface

// File: rtl/sdram_axi_arb_rr.sv
// Two-way round-robin picker.
//  req   in  2  request per port
//  ptr   in  1  preferred port when both request
//  idx   out 1  chosen port
//  valid out 1  any request present
module sdram_axi_arb_rr (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       idx,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (&req) begin
            idx = ptr;
        end else begin
            idx = req[1];
        end
    end

endmodule

// File: rtl/sdram_axi_arb2.sv
// 2:1 AXI4 arbiter in front of the SDRAM controller. Whole transactions are arbitrated,
// one outstanding transaction system-wide, round-robin between ports; beats pass through
// combinationally and responses are routed to the granted port.
//  clk_i   in  clock
//  rst_i   in  asynchronous active-high reset
//  s0, s1  slave  requester ports
//  m       master downstream controller port
//  grant_o out 2  one-hot owner, 0 when idle
module sdram_axi_arb2
    import sdram_axi_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    sdram_axi_arb2_if.slave        s0,
    sdram_axi_arb2_if.slave        s1,
    sdram_axi_arb2_if.master       m,
    output logic [1:0]             grant_o
);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic [1:0] wr_pref_q, wr_pref_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    // Owner-selected requester signals
    logic                own_awvalid, own_wvalid, own_wlast, own_bready;
    logic                own_arvalid, own_rready;
    logic [ADDR_W-1:0]   own_awaddr, own_araddr;
    logic [ID_W-1:0]     own_awid, own_arid;
    logic [7:0]          own_awlen, own_arlen;
    logic [1:0]          own_awburst, own_arburst;
    logic [DATA_W-1:0]   own_wdata;
    logic [DATA_W/8-1:0] own_wstrb;

    // Upstream-bound signals before steering to the owner
    logic                up_awready, up_wready, up_arready;
    logic                up_bvalid, up_rvalid, up_rlast;
    logic [1:0]          up_bresp, up_rresp;
    logic [ID_W-1:0]     up_bid, up_rid;
    logic [DATA_W-1:0]   up_rdata;

    logic pick_idx, pick_valid, pick_aw, pick_ar, pick_write;
    logic ar_hs, r_last_hs, aw_hs, w_last_hs, b_hs;

    sdram_axi_arb_rr u_rr (
        .req   ({s1.awvalid | s1.arvalid, s0.awvalid | s0.arvalid}),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        pick_aw = pick_idx ? s1.awvalid : s0.awvalid;
        pick_ar = pick_idx ? s1.arvalid : s0.arvalid;
        // Both channels pending: write wins only if this port's preference says so
        pick_write = pick_aw & (~pick_ar | wr_pref_q[pick_idx]);
    end

    always_comb begin
        own_awvalid = owner_q ? s1.awvalid : s0.awvalid;
        own_awaddr  = owner_q ? s1.awaddr  : s0.awaddr;
        own_awid    = owner_q ? s1.awid    : s0.awid;
        own_awlen   = owner_q ? s1.awlen   : s0.awlen;
        own_awburst = owner_q ? s1.awburst : s0.awburst;
        own_wvalid  = owner_q ? s1.wvalid  : s0.wvalid;
        own_wdata   = owner_q ? s1.wdata   : s0.wdata;
        own_wstrb   = owner_q ? s1.wstrb   : s0.wstrb;
        own_wlast   = owner_q ? s1.wlast   : s0.wlast;
        own_bready  = owner_q ? s1.bready  : s0.bready;
        own_arvalid = owner_q ? s1.arvalid : s0.arvalid;
        own_araddr  = owner_q ? s1.araddr  : s0.araddr;
        own_arid    = owner_q ? s1.arid    : s0.arid;
        own_arlen   = owner_q ? s1.arlen   : s0.arlen;
        own_arburst = owner_q ? s1.arburst : s0.arburst;
        own_rready  = owner_q ? s1.rready  : s0.rready;
    end

    // Handshakes as seen on the downstream port
    always_comb begin
        ar_hs     = (state_q == StAr) & own_arvalid & m.arready;
        r_last_hs = (state_q == StR) & m.rvalid & own_rready & m.rlast;
        aw_hs     = (state_q == StWr) & ~aw_done_q & own_awvalid & m.awready;
        w_last_hs = (state_q == StWr) & ~w_done_q & own_wvalid & m.wready & own_wlast;
        b_hs      = (state_q == StB) & m.bvalid & own_bready;
    end

    // Channel forwarding; anything outside the active state is held at 0
    always_comb begin
        m.awvalid  = 1'b0;
        m.awaddr   = '0;
        m.awid     = '0;
        m.awlen    = '0;
        m.awburst  = '0;
        m.wvalid   = 1'b0;
        m.wdata    = '0;
        m.wstrb    = '0;
        m.wlast    = 1'b0;
        m.bready   = 1'b0;
        m.arvalid  = 1'b0;
        m.araddr   = '0;
        m.arid     = '0;
        m.arlen    = '0;
        m.arburst  = '0;
        m.rready   = 1'b0;
        up_awready = 1'b0;
        up_wready  = 1'b0;
        up_arready = 1'b0;
        up_bvalid  = 1'b0;
        up_bresp   = '0;
        up_bid     = '0;
        up_rvalid  = 1'b0;
        up_rdata   = '0;
        up_rresp   = '0;
        up_rid     = '0;
        up_rlast   = 1'b0;
        unique case (state_q)
            StAr: begin
                m.arvalid  = own_arvalid;
                m.araddr   = own_araddr;
                m.arid     = own_arid;
                m.arlen    = own_arlen;
                m.arburst  = own_arburst;
                up_arready = m.arready;
            end
            StR: begin
                up_rvalid = m.rvalid;
                up_rdata  = m.rdata;
                up_rresp  = m.rresp;
                up_rid    = m.rid;
                up_rlast  = m.rlast;
                m.rready  = own_rready;
            end
            StWr: begin
                if (!aw_done_q) begin
                    m.awvalid  = own_awvalid;
                    m.awaddr   = own_awaddr;
                    m.awid     = own_awid;
                    m.awlen    = own_awlen;
                    m.awburst  = own_awburst;
                    up_awready = m.awready;
                end
                if (!w_done_q) begin
                    m.wvalid  = own_wvalid;
                    m.wdata   = own_wdata;
                    m.wstrb   = own_wstrb;
                    m.wlast   = own_wlast;
                    up_wready = m.wready;
                end
            end
            StB: begin
                up_bvalid = m.bvalid;
                up_bresp  = m.bresp;
                up_bid    = m.bid;
                m.bready  = own_bready;
            end
            default: ;
        endcase
    end

    // Steer upstream signals to the owner only
    always_comb begin
        logic sel0;
        sel0       = (owner_q == PortS0);
        s0.awready = sel0 & up_awready;
        s0.wready  = sel0 & up_wready;
        s0.arready = sel0 & up_arready;
        s0.bvalid  = sel0 & up_bvalid;
        s0.bresp   = sel0 ? up_bresp : '0;
        s0.bid     = sel0 ? up_bid   : '0;
        s0.rvalid  = sel0 & up_rvalid;
        s0.rdata   = sel0 ? up_rdata : '0;
        s0.rresp   = sel0 ? up_rresp : '0;
        s0.rid     = sel0 ? up_rid   : '0;
        s0.rlast   = sel0 & up_rlast;
    end

    always_comb begin
        logic sel1;
        sel1       = (owner_q == PortS1);
        s1.awready = sel1 & up_awready;
        s1.wready  = sel1 & up_wready;
        s1.arready = sel1 & up_arready;
        s1.bvalid  = sel1 & up_bvalid;
        s1.bresp   = sel1 ? up_bresp : '0;
        s1.bid     = sel1 ? up_bid   : '0;
        s1.rvalid  = sel1 & up_rvalid;
        s1.rdata   = sel1 ? up_rdata : '0;
        s1.rresp   = sel1 ? up_rresp : '0;
        s1.rid     = sel1 ? up_rid   : '0;
        s1.rlast   = sel1 & up_rlast;
    end

    always_comb begin
        grant_o = (state_q == StIdle) ? 2'b00 : port_onehot(owner_q);
    end

    // Next-state
    always_comb begin
        logic finish;
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        wr_pref_d = wr_pref_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        finish    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    state_d = pick_write ? StWr : StAr;
                end
            end
            StAr: begin
                if (ar_hs) begin
                    state_d = StR;
                end
            end
            StR: finish = r_last_hs;
            StWr: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_last_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = StB;
                end
            end
            StB: finish = b_hs;
            default: state_d = StIdle;
        endcase
        if (finish) begin
            state_d            = StIdle;
            rr_ptr_d           = ~owner_q;
            // After a read, this port prefers a write next time, and vice versa
            wr_pref_d[owner_q] = (state_q == StR);
            aw_done_d          = 1'b0;
            w_done_d           = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            rr_ptr_q  <= 1'b0;
            wr_pref_q <= 2'b00;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_pref_q <= wr_pref_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule
